// File: rtl/alarm_sequencer.sv
// alarm_sequencer: latched alarm compare, ring/snooze/timeout FSM and debounced stop/snooze buttons.
// Define ALARM_SNOOZE_EN to build the snooze state, snooze button path and snooze counter.
module alarm_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned RING_TIMEOUT_S  = 60,
  parameter int unsigned SNOOZE_MIN      = 5,
  parameter int unsigned MAX_SNOOZE      = 3
) (
  input  logic       clk_50M,
  input  logic       reset_all,
  input  logic       tick_1hz,
  input  logic [5:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       enable_alarm,
  input  logic       set_alarm,
  input  logic [5:0] hour_alarm,
  input  logic [5:0] minute_alarm,
  input  logic       snooze_n,
  input  logic       stop_n,
  output logic       ring,
  output logic       beep,
  output logic       load_err,
  output logic [1:0] alarm_state,
  output logic [2:0] snooze_cnt
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StArmed   = 2'b01,
    StRinging = 2'b10,
    StSnooze  = 2'b11
  } state_e;

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned NumBtn = 2;
  logic [NumBtn-1:0] btn_raw;
  assign btn_raw = {snooze_n, stop_n};
`else
  localparam int unsigned NumBtn = 1;
  logic [NumBtn-1:0] btn_raw;
  logic [7:0]        unused_snooze;
  assign btn_raw       = stop_n;
  assign unused_snooze = {snooze_n, 7'(SNOOZE_MIN + MAX_SNOOZE)};
`endif

  logic [NumBtn-1:0] press;

  // Debounced level flips only after CntMax+1 consecutive disagreeing samples.
  for (genvar i = 0; i < NumBtn; i++) begin : g_btn
    logic            sync1_q, sync2_q, level_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_50M or posedge reset_all) begin
      if (reset_all) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        level_q <= 1'b1;
        cnt_q   <= '0;
      end else begin
        sync1_q <= btn_raw[i];
        sync2_q <= sync1_q;
        if (sync2_q == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CntMax) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end
    end

    assign press[i] = level_q & ~sync2_q & (cnt_q == CntMax);
  end

  logic stop_ev;
  assign stop_ev = press[0];

  state_e     state_q, state_d;
  logic       beep_q, beep_d;
  logic       load_err_q;
  logic [2:0] snz_cnt_q, snz_cnt_d;
  logic [7:0] timer_q, timer_d;
  logic [5:0] alm_h_q, alm_m_q;
  logic       load_ok, at_zero, match_alarm;

  assign load_ok     = (hour_alarm <= 6'd23) && (minute_alarm <= 6'd59);
  assign at_zero     = tick_1hz && (seconds == 6'd0);
  assign match_alarm = at_zero && (hours == alm_h_q) && (minutes == alm_m_q);

`ifdef ALARM_SNOOZE_EN
  logic       snooze_ev, match_tgt, carry;
  logic [5:0] tgt_h_q, tgt_m_q, tgt_h_d, tgt_m_d, nxt_h, nxt_m, hour_inc;
  logic [6:0] min_sum;

  assign snooze_ev = press[1];
  assign match_tgt = at_zero && (hours == tgt_h_q) && (minutes == tgt_m_q);
  assign min_sum   = {1'b0, minutes} + 7'(SNOOZE_MIN);
  assign carry     = (min_sum >= 7'd60);
  assign nxt_m     = carry ? 6'(min_sum - 7'd60) : min_sum[5:0];
  assign hour_inc  = hours + {5'd0, carry};
  assign nxt_h     = (hour_inc >= 6'd24) ? 6'd0 : hour_inc;
`endif

  always_comb begin
    state_d   = state_q;
    beep_d    = beep_q;
    timer_d   = timer_q;
    snz_cnt_d = snz_cnt_q;
`ifdef ALARM_SNOOZE_EN
    tgt_h_d   = tgt_h_q;
    tgt_m_d   = tgt_m_q;
`endif
    if (!enable_alarm) begin
      state_d   = StIdle;
      beep_d    = 1'b0;
      snz_cnt_d = '0;
    end else if (set_alarm && load_ok && (state_q == StRinging || state_q == StSnooze)) begin
      state_d   = StArmed;
      beep_d    = 1'b0;
      snz_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StArmed;
        StArmed: begin
          if (match_alarm) begin
            state_d = StRinging;
            timer_d = 8'(RING_TIMEOUT_S);
            beep_d  = 1'b1;
          end
        end
        StRinging: begin
          if (stop_ev) begin
            state_d   = StArmed;
            beep_d    = 1'b0;
            snz_cnt_d = '0;
          end
`ifdef ALARM_SNOOZE_EN
          else if (snooze_ev && (snz_cnt_q < 3'(MAX_SNOOZE))) begin
            state_d   = StSnooze;
            beep_d    = 1'b0;
            snz_cnt_d = snz_cnt_q + 3'd1;
            tgt_h_d   = nxt_h;
            tgt_m_d   = nxt_m;
          end
`endif
          else if (tick_1hz) begin
            if (timer_q <= 8'd1) begin
              state_d   = StArmed;
              beep_d    = 1'b0;
              snz_cnt_d = '0;
            end else begin
              timer_d = timer_q - 8'd1;
              beep_d  = ~beep_q;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        StSnooze: begin
          if (stop_ev) begin
            state_d   = StArmed;
            snz_cnt_d = '0;
          end else if (match_tgt) begin
            state_d = StRinging;
            timer_d = 8'(RING_TIMEOUT_S);
            beep_d  = 1'b1;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_50M or posedge reset_all) begin
    if (reset_all) begin
      state_q    <= StIdle;
      beep_q     <= 1'b0;
      load_err_q <= 1'b0;
      snz_cnt_q  <= '0;
      timer_q    <= '0;
      alm_h_q    <= '0;
      alm_m_q    <= '0;
    end else begin
      state_q    <= state_d;
      beep_q     <= beep_d;
      load_err_q <= set_alarm & ~load_ok;
      snz_cnt_q  <= snz_cnt_d;
      timer_q    <= timer_d;
      if (set_alarm && load_ok) begin
        alm_h_q <= hour_alarm;
        alm_m_q <= minute_alarm;
      end
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk_50M or posedge reset_all) begin
    if (reset_all) begin
      tgt_h_q <= '0;
      tgt_m_q <= '0;
    end else begin
      tgt_h_q <= tgt_h_d;
      tgt_m_q <= tgt_m_d;
    end
  end
`endif

  assign ring        = (state_q == StRinging);
  assign beep        = beep_q;
  assign load_err    = load_err_q;
  assign alarm_state = state_q;
  assign snooze_cnt  = snz_cnt_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: behavioural model compared every cycle, plus literal spot checks.
// Snooze scenarios run only when ALARM_SNOOZE_EN is defined.
module tb_alarm_sequencer;

  localparam int DB = 4;
  localparam int RT = 60;
  localparam int SM = 5;
  localparam int MS = 3;
`ifdef ALARM_SNOOZE_EN
  localparam bit SnzEn = 1'b1;
`else
  localparam bit SnzEn = 1'b0;
`endif

  logic       clk, rst, tick_1hz, enable_alarm, set_alarm, snooze_n, stop_n;
  logic [5:0] hours, minutes, seconds, hour_alarm, minute_alarm;
  logic       ring, beep, load_err;
  logic [1:0] alarm_state;
  logic [2:0] snooze_cnt;

  alarm_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .RING_TIMEOUT_S (RT),
    .SNOOZE_MIN     (SM),
    .MAX_SNOOZE     (MS)
  ) dut (
    .clk_50M     (clk),
    .reset_all   (rst),
    .tick_1hz    (tick_1hz),
    .hours       (hours),
    .minutes     (minutes),
    .seconds     (seconds),
    .enable_alarm(enable_alarm),
    .set_alarm   (set_alarm),
    .hour_alarm  (hour_alarm),
    .minute_alarm(minute_alarm),
    .snooze_n    (snooze_n),
    .stop_n      (stop_n),
    .ring        (ring),
    .beep        (beep),
    .load_err    (load_err),
    .alarm_state (alarm_state),
    .snooze_cnt  (snooze_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: st 0 idle, 1 armed, 2 ringing, 3 snooze; times kept as plain integers.
  typedef struct {
    int st, cnt, timer, ah, am, th, tm;
    bit beep, lerr, sdb, zdb;
  } mdl_t;

  mdl_t m;
  bit stop_h[$];
  bit snz_h[$];

  function automatic mdl_t model_reset();
    mdl_t r;
    r.st = 0; r.cnt = 0; r.timer = 0; r.ah = 0; r.am = 0; r.th = 0; r.tm = 0;
    r.beep = 1'b0; r.lerr = 1'b0; r.sdb = 1'b1; r.zdb = 1'b1;
    return r;
  endfunction

  // A button level counts as settled when the DB raw samples, seen through the 2-stage
  // synchroniser (so ending two samples before the newest), all equal v.
  function automatic bit settled(input bit h[$], input bit v);
    for (int j = 0; j < DB; j++) if (h[h.size() - 2 - j] != v) return 1'b0;
    return 1'b1;
  endfunction

  function automatic mdl_t step(input mdl_t c, input bit sh[$], input bit zh[$]);
    mdl_t n = c;
    bit stop_ev = c.sdb && settled(sh, 1'b0);
    bit snz_ev  = c.zdb && settled(zh, 1'b0);
    bit ok      = (int'(hour_alarm) <= 23) && (int'(minute_alarm) <= 59);
    bit at0     = tick_1hz && (seconds == 0);
    int t;
    if (c.sdb && settled(sh, 1'b0)) n.sdb = 1'b0;
    else if (!c.sdb && settled(sh, 1'b1)) n.sdb = 1'b1;
    if (c.zdb && settled(zh, 1'b0)) n.zdb = 1'b0;
    else if (!c.zdb && settled(zh, 1'b1)) n.zdb = 1'b1;
    n.lerr = set_alarm && !ok;
    if (set_alarm && ok) begin
      n.ah = int'(hour_alarm);
      n.am = int'(minute_alarm);
    end
    if (!enable_alarm) begin
      n.st = 0; n.cnt = 0; n.beep = 1'b0;
    end else if (set_alarm && ok && c.st >= 2) begin
      n.st = 1; n.cnt = 0; n.beep = 1'b0;
    end else begin
      case (c.st)
        0: n.st = 1;
        1: if (at0 && int'(hours) == c.ah && int'(minutes) == c.am) begin
          n.st = 2; n.timer = RT; n.beep = 1'b1;
        end
        2: begin
          if (stop_ev) begin
            n.st = 1; n.cnt = 0; n.beep = 1'b0;
          end else if (SnzEn && snz_ev && c.cnt < MS) begin
            n.st = 3; n.cnt = c.cnt + 1; n.beep = 1'b0;
            t = (int'(hours) * 60 + int'(minutes) + SM) % 1440;
            n.th = t / 60;
            n.tm = t % 60;
          end else if (tick_1hz) begin
            n.timer = c.timer - 1;
            if (n.timer == 0) begin
              n.st = 1; n.cnt = 0; n.beep = 1'b0;
            end else begin
              n.beep = !c.beep;
            end
          end
        end
        default: begin
          if (stop_ev) begin
            n.st = 1; n.cnt = 0;
          end else if (at0 && int'(hours) == c.th && int'(minutes) == c.tm) begin
            n.st = 2; n.timer = RT; n.beep = 1'b1;
          end
        end
      endcase
    end
    return n;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m = model_reset();
        stop_h.delete();
        snz_h.delete();
        for (int j = 0; j < DB + 2; j++) begin
          stop_h.push_back(1'b1);
          snz_h.push_back(1'b1);
        end
      end else begin
        m = step(m, stop_h, snz_h);
        stop_h.push_back(stop_n);
        snz_h.push_back(snooze_n);
        if (stop_h.size() > DB + 4) begin
          void'(stop_h.pop_front());
          void'(snz_h.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on && !rst) begin
        chk("ring", ring, m.st == 2);
        chk("beep", beep, m.beep);
        chk("load_err", load_err, m.lerr);
        chk("alarm_state", alarm_state, m.st);
        chk("snooze_cnt", snooze_cnt, m.cnt);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int h, input int mi);
    @(negedge clk);
    set_alarm = 1'b1; hour_alarm = 6'(h); minute_alarm = 6'(mi);
    @(negedge clk);
    set_alarm = 1'b0;
  endtask

  task automatic tick_to(input int h, input int mi, input int s);
    @(negedge clk);
    tick_1hz = 1'b1; hours = 6'(h); minutes = 6'(mi); seconds = 6'(s);
    @(negedge clk);
    tick_1hz = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable_alarm = 1'b0; set_alarm = 1'b0; tick_1hz = 1'b0;
    hours = '0; minutes = '0; seconds = '0; hour_alarm = '0; minute_alarm = '0;
    stop_n = 1'b1; snooze_n = 1'b1;
    #12;
    chk("rst_ring", ring, 0);
    chk("rst_beep", beep, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_state", alarm_state, 0);
    chk("rst_snooze_cnt", snooze_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;

    load(7, 30);
    chk("load_ok_no_err", load_err, 0);
    enable_alarm = 1'b1;
    cyc(2);
    chk("armed", alarm_state, 1);

    tick_to(7, 29, 58); cyc(1);
    tick_to(7, 29, 59);
    chk("no_ring_early", ring, 0);
    cyc(1);
    tick_to(7, 30, 0);
    chk("ring_on_match", ring, 1);
    chk("beep_first", beep, 1);
    chk("state_ringing", alarm_state, 2);
    cyc(1); tick_to(7, 30, 1);
    chk("beep_second", beep, 0);
    cyc(1); tick_to(7, 30, 2);
    chk("beep_third", beep, 1);

    load(24, 10);
    chk("load_err_24_10", load_err, 1);
    cyc(1);
    chk("load_err_one_cycle", load_err, 0);
    load(25, 0);
    chk("load_err_25_00", load_err, 1);

    // Short bounces must not register as a press.
    for (int g = 0; g < 2; g++) begin
      stop_n = 1'b0; cyc(3);
      stop_n = 1'b1; cyc(3);
    end
    chk("bounce_ignored", alarm_state, 2);
    stop_n = 1'b0; cyc(10);
    chk("stop_to_armed", alarm_state, 1);
    chk("stop_ring_off", ring, 0);
    stop_n = 1'b1; cyc(8);

    tick_to(7, 30, 0);
    chk("alarm_kept_0730", ring, 1);
    for (int i = 1; i <= RT; i++) begin
      cyc(1);
      tick_to(7, 30 + i / 60, i % 60);
      if (i == RT - 1) chk("ring_before_timeout", ring, 1);
    end
    chk("timeout_ring_off", ring, 0);
    chk("timeout_armed", alarm_state, 1);

`ifdef ALARM_SNOOZE_EN
    load(23, 58);
    cyc(1);
    tick_to(23, 58, 0);
    chk("snz_ring_2358", ring, 1);
    for (int i = 1; i <= MS; i++) begin
      snooze_n = 1'b0; cyc(8);
      chk("snz_state", alarm_state, 3);
      chk("snz_count", snooze_cnt, i);
      snooze_n = 1'b1; cyc(8);
      tick_to(0, 5 * i - 2, 0);
      chk("snz_ring_again", ring, 1);
    end
    snooze_n = 1'b0; cyc(8);
    snooze_n = 1'b1; cyc(8);
    chk("snz_limit_ring", ring, 1);
    chk("snz_limit_cnt", snooze_cnt, MS);
    stop_n = 1'b0; cyc(8);
    stop_n = 1'b1; cyc(8);
    chk("snz_stop_armed", alarm_state, 1);
    chk("snz_stop_cnt", snooze_cnt, 0);
    load(7, 30);
`endif

    cyc(1);
    tick_to(7, 30, 0);
    chk("ring_before_disable", ring, 1);
    enable_alarm = 1'b0;
    cyc(1);
    chk("disable_idle", alarm_state, 0);
    chk("disable_ring_off", ring, 0);
    enable_alarm = 1'b1;
    cyc(2);
    chk("reenable_armed", alarm_state, 1);

    tick_to(7, 30, 0);
    chk("ring_before_reset", ring, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ring", ring, 0);
    chk("async_rst_beep", beep, 0);
    chk("async_rst_state", alarm_state, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(3);
    chk("after_reset_armed", alarm_state, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
